// File: rtl/gray_rd_ptr_if.sv
// gray_rd_ptr_if: read-side pointer bundle between the FIFO consumer, the RAM and the write-domain crossing
interface gray_rd_ptr_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] wgray_i;
    logic             rd_en;
    logic [WIDTH-1:0] rgray_o;
    logic [WIDTH-2:0] raddr_o;
    logic             empty_o;
    logic [WIDTH-1:0] level_o;
    logic             rd_fire_o;
    logic [1:0]       err_o;

    modport master (
        output wgray_i, rd_en,
        input  rgray_o, raddr_o, empty_o, level_o, rd_fire_o, err_o
    );

    modport slave (
        input  wgray_i, rd_en,
        output rgray_o, raddr_o, empty_o, level_o, rd_fire_o, err_o
    );
endinterface

// File: rtl/gray_rd_ptr.sv
// gray_rd_ptr: read-domain pointer of a Gray-crossing dual-clock FIFO (wgray sync, rbin/rgray, empty, level).
// Define GRAY_RD_CHECK_EN to build the sticky err_o checkers; otherwise err_o is tied to 0.
module gray_rd_ptr #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic          rclk,
    input logic          rrst_n,
    gray_rd_ptr_if.slave bus
);
    localparam logic [WIDTH-1:0] DEPTH = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        for (int i = 0; i < WIDTH; i++) b = b ^ (g >> i);
        return b;
    endfunction

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] wsync, wbin, rbin, rbin_next, level_next;

    // plain flop chain: no logic between stages keeps the crossing metastability-safe
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= bus.wgray_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign wsync         = sync_q[SYNC_STAGES-1];
    assign wbin          = gray2bin(wsync);
    assign bus.rd_fire_o = bus.rd_en & ~bus.empty_o;
    assign rbin_next     = rbin + WIDTH'(bus.rd_fire_o);
    assign level_next    = wbin - rbin_next;
    assign bus.raddr_o   = rbin[WIDTH-2:0];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin        <= '0;
            bus.rgray_o <= '0;
            bus.empty_o <= 1'b1;
            bus.level_o <= '0;
        end else begin
            rbin        <= rbin_next;
            bus.rgray_o <= rbin_next ^ (rbin_next >> 1);
            bus.empty_o <= wbin == rbin_next;
            bus.level_o <= level_next;
        end
    end

`ifdef GRAY_RD_CHECK_EN
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) bus.err_o <= '0;
        else bus.err_o <= bus.err_o | {level_next > DEPTH, bus.rd_en & bus.empty_o};
    end
`else
    assign bus.err_o = '0;
`endif
endmodule

// File: doc/gray_rd_ptr.md
# gray_rd_ptr

Read-side pointer controller for the dual-clock FIFO built on the Gray-code counter crossing. It synchronizes the writer's Gray pointer into the read clock domain and converts it back to binary. It keeps the read pointer in binary and in Gray, and generates `empty`, fill `level` and the RAM read address from a single-cycle `rd_en`/`empty` handshake. It is the receiving end of the write-pointer crossing and the source of the read pointer returned to the writer for `full` generation.

## Interface
Parameters:
- `WIDTH`, 4: pointer width. Address is `WIDTH-1` bits plus 1 wrap bit. FIFO depth is `2**(WIDTH-1)`.
- `SYNC_STAGES`, 2: flops in the `wgray_i` synchronizer. Minimum 2.

Ports:
- `rclk`  in  1: read clock. All logic runs on `rclk` only.
- `rrst_n`  in  1: asynchronous reset, active-low. Release is synchronous to `rclk` (handled externally).
- `wgray_i`  in  WIDTH: writer Gray pointer, driven from the `wclk` domain and asynchronous to `rclk`.
- `rd_en`  in  1: read request from the consumer.
- `rgray_o`  out  WIDTH: registered Gray read pointer, sent to the writer domain.
- `raddr_o`  out  WIDTH-1: RAM read address, equal to `rbin[WIDTH-2:0]`.
- `empty_o`  out  1: registered empty flag.
- `level_o`  out  WIDTH: registered fill level, range 0..`2**(WIDTH-1)`.
- `rd_fire_o`  out  1: combinational, `rd_en & ~empty_o`. Marks an accepted read.
- `err_o`  out  2: sticky errors. Bit 0 = read while empty. Bit 1 = level overflow. Present only with the macro (see Configuration).

## Operation
- Synchronizer: a `SYNC_STAGES`-deep shift register of `wgray_i`. No logic between its stages. Only the last stage `wsync` is used.
- `wbin = gray2bin(wsync)`. Conversion is an XOR-prefix from the MSB down, combinational.
- Handshake: a read is accepted in a cycle where `rd_en=1` and `empty_o=0`.
  - `rd_en=1` while `empty_o=1` is ignored: pointer unchanged, no RAM access implied.
- Read pointer update:
  - `rbin_next = rbin + rd_fire_o`, modulo `2**WIDTH`.
  - On each edge: `rbin <= rbin_next` and `rgray_o <= rbin_next ^ (rbin_next >> 1)`.
- Empty and level, registered each edge:
  - `empty_o <= (wbin == rbin_next)`.
  - `level_o <= (wbin - rbin_next)`, modulo `2**WIDTH`.
- Wrap-around: pointers wrap from `2**WIDTH-1` to 0 with no special casing. `rgray_o` changes exactly one bit per accepted read, including at the wrap.
- Full FIFO: when `wbin - rbin == 2**(WIDTH-1)`, the level reports depth. This is a legal value.
- Reset: asynchronous, active-low, may be asserted at any point.
  - Sync stages, `rbin` and `rgray_o` clear to 0.
  - `empty_o` = 1, `level_o` = 0, `err_o` = 0.
  - A read in flight at reset assertion is dropped.

## Timing
- `wgray_i` first sampled at edge N:
  - `wsync` holds the value after edge N+`SYNC_STAGES`-1.
  - `empty_o`/`level_o` reflect it after edge N+`SYNC_STAGES`. With the default, that is 2 edges after sampling.
- Accepted read at edge M:
  - `raddr_o`, `rgray_o`, `empty_o` and `level_o` all update after edge M. Read-to-flag latency is 1 cycle.
  - Back-to-back reads are allowed every cycle. Each cycle's fire uses that cycle's `empty_o`.
- `empty_o` is pessimistic: it may stay asserted up to `SYNC_STAGES`+1 cycles after a write. It is never deasserted falsely.
- Simultaneous write-pointer change and read in the same cycle: both are applied in the same registered update. The level is the net of the two.
- `wgray_i` can advance several steps between `rclk` edges (fast writer). The multi-step Gray value is consumed as sampled and the level jumps accordingly.

## Configuration
- `GRAY_RD_CHECK_EN` defined:
  - `err_o[0]` sets when `rd_en=1` and `empty_o=1`.
  - `err_o[1]` sets when the computed level exceeds `2**(WIDTH-1)`.
  - Both are sticky until reset.
- `GRAY_RD_CHECK_EN` undefined: `err_o` is tied to 0 and no checking logic is built. All other behaviour is identical.

## Test plan
- Reset with `wgray_i`=0 → `empty_o`=1, `level_o`=0, `rgray_o`=0, `raddr_o`=0. Assert `rrst_n` mid-stream → the same values appear immediately, without waiting for a clock edge.
- `wgray_i` 0→1 (bin 1) sampled at edge N, defaults → `empty_o` falls and `level_o`=1 after edge N+2. `rd_en`=1 for one cycle → `raddr_o`=1, `rgray_o`=4'b0001, `empty_o`=1.
- Writer advances bin 0→8 (Gray 4'b1100), WIDTH=4 → `level_o`=8 (full). Then 8 back-to-back reads → `raddr_o` steps 1..7,0, `level_o` steps 7..0, `empty_o`=1 after the 8th read.
- Wrap: drive 20 writes and 20 reads, interleaved at the 10/14 ns clock ratio → `rgray_o` changes exactly one bit per read, including 15→0 (4'b1000→4'b0000). Ends with `level_o`=0.
- `rd_en`=1 held while empty for 3 cycles → pointer stays at 0, `rd_fire_o`=0. With `GRAY_RD_CHECK_EN`, `err_o[0]`=1 and stays set.
- With `GRAY_RD_CHECK_EN`, force `wgray_i` to bin 9 while `rbin`=0 → `err_o[1]`=1 two cycles after sampling. Without the macro, `err_o`=2'b00.
